// File: rtl/add_seq_ctrl.sv
// Multi-cycle wide adder: one SLICE-bit adder is reused over WIDTH/SLICE cycles with a registered carry.
// Optional subtract support is compiled in with `define ADD_SEQ_SUB_EN.
//
// state  | meaning
// S_IDLE | waiting for operands, in_ready high
// S_RUN  | adding one slice per clock, idx_q selects the slice
// S_DONE | result held on sum/cout with out_valid high until out_ready
module add_seq_ctrl #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              carry_q, carry_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [SLICE:0]    slice_sum;

  // Operands shift down one slice per cycle, so the adder always sees bit 0 upward.
  assign slice_sum = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]} + {{SLICE{1'b0}}, carry_q};

`ifndef ADD_SEQ_SUB_EN
  logic unused_op;
  assign unused_op = op;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b0;
          idx_d   = '0;
`ifdef ADD_SEQ_SUB_EN
          // Subtract as a + ~b + 1; the op decision lives in the stored b and the seed carry.
          if (op) begin
            b_d     = ~b;
            carry_d = 1'b1;
          end
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < NSLICE; i++) begin
          if (idx_q == IDXW'(i)) sum_d[i*SLICE +: SLICE] = slice_sum[SLICE-1:0];
        end
        carry_d = slice_sum[SLICE];
        a_d     = a_q >> SLICE;
        b_d     = b_q >> SLICE;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = slice_sum[SLICE];
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl at WIDTH=64, SLICE=16; expected results flow through a queue.
module tb_add_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a, b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;

  int total = 0;
  int bad   = 0;
  logic [64:0] exp_q[$];

  add_seq_ctrl #(.WIDTH(64), .SLICE(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [64:0] model(input logic [63:0] av, input logic [63:0] bv, input logic opv);
`ifdef ADD_SEQ_SUB_EN
    if (opv) return {1'b0, av} + {1'b0, ~bv} + 65'd1;
`endif
    return {1'b0, av} + {1'b0, bv};
  endfunction

  // Drives one operand transfer, queues its expected result, waits for out_valid.
  task automatic send_op(input logic [63:0] av, input logic [63:0] bv, input logic opv,
                         input logic [64:0] expv, output int lat, output bit ok);
    int n;
    ok = 1'b0;
    lat = 0;
    a = av; b = bv; op = opv; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) begin in_valid = 1'b0; return; end
    tick();
    exp_q.push_back(expv);
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; op = ~opv;
    while (lat < 20) begin
      tick();
      lat++;
      if (out_valid) begin ok = 1'b1; return; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; a = '1; b = '1; op = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (sum !== 64'd0) begin bad++; $display("FAIL reset_sum got=%h want=0", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", cout); end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_carry_chain();
    int lat; bit ok; logic [64:0] e;
    out_ready = 1'b0;
    send_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, {1'b1, 64'd0}, lat, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL wrap_timeout got=%b want=1", ok); end
    total++; if (lat !== 4) begin bad++; $display("FAIL wrap_latency got=%0d want=4", lat); end
    e = exp_q.pop_front();
    total++; if ({cout, sum} !== e) begin bad++; $display("FAIL wrap_result got=%h want=%h", {cout, sum}, e); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL wrap_release got=%b want=1", in_ready); end

    send_op(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, {1'b0, 64'h1_0000}, lat, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL slice_carry_timeout got=%b want=1", ok); end
    e = exp_q.pop_front();
    total++; if ({cout, sum} !== e) begin bad++; $display("FAIL slice_carry_result got=%h want=%h", {cout, sum}, e); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat; bit ok; logic [64:0] e;
    out_ready = 1'b0;
    send_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
            model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0), lat, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL bp_timeout got=%b want=1", ok); end
    e = exp_q.pop_front();
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; a = {$urandom, $urandom}; b = {$urandom, $urandom};
      tick();
      total++; if ({cout, sum} !== e) begin bad++; $display("FAIL bp_hold cyc=%0d got=%h want=%h", i, {cout, sum}, e); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=0", i, in_ready); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc=%0d got=%b want=1", i, out_valid); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid got=%b want=0", out_valid); end
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_no_ghost_accept got=%b want=1", in_ready); end
  endtask

  task automatic test_reset_abort();
    int lat; bit ok; logic [64:0] e;
    out_ready = 1'b0;
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; op = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_out_valid got=%b want=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready got=%b want=1", in_ready); end
    total++; if (sum !== 64'd0) begin bad++; $display("FAIL abort_sum got=%h want=0", sum); end
    total++; if (cout !== 1'b0) begin bad++; $display("FAIL abort_cout got=%b want=0", cout); end
    send_op(64'd3, 64'd4, 1'b0, 65'd7, lat, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL after_abort_timeout got=%b want=1", ok); end
    e = exp_q.pop_front();
    total++; if ({cout, sum} !== e) begin bad++; $display("FAIL after_abort_result got=%h want=%h", {cout, sum}, e); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_subtract();
    int lat; bit ok; logic [64:0] e;
    out_ready = 1'b0;
`ifdef ADD_SEQ_SUB_EN
    send_op(64'd5, 64'd7, 1'b1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE}, lat, ok);
`else
    send_op(64'd5, 64'd7, 1'b1, 65'd12, lat, ok);
`endif
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL sub_a_timeout got=%b want=1", ok); end
    e = exp_q.pop_front();
    total++; if ({cout, sum} !== e) begin bad++; $display("FAIL sub_5_7 got=%h want=%h", {cout, sum}, e); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
`ifdef ADD_SEQ_SUB_EN
    send_op(64'd7, 64'd5, 1'b1, {1'b1, 64'd2}, lat, ok);
`else
    send_op(64'd7, 64'd5, 1'b1, 65'd12, lat, ok);
`endif
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL sub_b_timeout got=%b want=1", ok); end
    e = exp_q.pop_front();
    total++; if ({cout, sum} !== e) begin bad++; $display("FAIL sub_7_5 got=%h want=%h", {cout, sum}, e); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int rcv;
    int cyc;
    bit prod_ok;
    prod_ok = 1'b1;
    rcv = 0;
    cyc = 0;
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < 1000 && prod_ok; i++) begin
          int gap;
          int n;
          logic acc;
          logic [63:0] av, bv;
          logic opv;
          gap = $urandom_range(0, 2);
          in_valid = 1'b0;
          repeat (gap) tick();
          av = {$urandom, $urandom}; bv = {$urandom, $urandom}; opv = $urandom_range(0, 1);
          if (i % 7 == 0) bv = ~av;
          a = av; b = bv; op = opv; in_valid = 1'b1;
          n = 0;
          acc = 1'b0;
          while (!acc && n < 100) begin
            acc = in_ready;
            tick();
            n++;
          end
          if (acc) exp_q.push_back(model(av, bv, opv));
          else prod_ok = 1'b0;
        end
        in_valid = 1'b0;
      end
      begin
        while (rcv < 1000 && cyc < 40000) begin
          logic hs;
          logic [64:0] got;
          logic [64:0] e;
          out_ready = $urandom_range(0, 1);
          hs = out_valid && out_ready;
          got = {cout, sum};
          tick();
          cyc++;
          if (hs) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++; $display("FAIL b2b_unexpected_output got=%h want=none", got);
            end else begin
              e = exp_q.pop_front();
              if (got !== e) begin bad++; $display("FAIL b2b_result n=%0d got=%h want=%h", rcv, got, e); end
            end
            rcv++;
          end
        end
        out_ready = 1'b0;
      end
    join
    total++; if (prod_ok !== 1'b1) begin bad++; $display("FAIL b2b_accept_timeout got=%b want=1", prod_ok); end
    total++; if (rcv !== 1000) begin bad++; $display("FAIL b2b_count got=%0d want=1000", rcv); end
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL b2b_leftover got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0; out_ready = 1'b0;
    test_reset();
    test_carry_chain();
    test_backpressure();
    test_reset_abort();
    test_subtract();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
